chacha_stream_ctrl: RTL and testbench
=====================================

// Module: chacha_stream_ctrl
//
// PURPOSE
//   Multi-block sequencer for the ChaCha20 encryption core (the core XORs one 512-bit block per request).
//   - Takes a message of num_blocks 512-bit words on a valid/ready input stream.
//   - Issues one core request per word (init for the first, next for the rest) and auto-increments the 64-bit block counter.
//   - Returns the ciphertext on a valid/ready output stream, with last-beat marking and a done pulse.
//   - Sits between the DMA/stream fabric and the ChaCha core instance.
//
// PARAMETERS
//   CNT_W  16  width of num_blocks and the internal remaining-block counter
//
// PORTS
//   clk                  in   1      system clock
//   reset                in   1      asynchronous, active-high reset
//   start                in   1      1-cycle pulse: latch cfg_* and begin a message (ignored when busy=1)
//   cfg_key              in   256    key, latched on accepted start
//   cfg_iv               in   64     nonce, latched on accepted start
//   cfg_ctr0             in   64     initial block counter, latched on accepted start
//   cfg_num_blocks       in   CNT_W  blocks in message; 0 is legal
//   busy                 out  1      message in progress
//   done                 out  1      1-cycle pulse after the last output beat handshakes (or the empty message)
//   err                  out  1      counter-wrap error, sticky until next accepted start (macro only, else tied 0)
//   s_valid              in   1      input block valid
//   s_ready              out  1      input block ready
//   s_data               in   512    plaintext block
//   m_valid              out  1      output block valid
//   m_ready              in   1      output block ready
//   m_data               out  512    ciphertext block
//   m_last               out  1      qualifies m_valid: final block of message
//   core_init            out  1      1-cycle request, first block
//   core_next            out  1      1-cycle request, subsequent blocks
//   core_key             out  256    latched key
//   core_ctr             out  64     current block counter
//   core_iv              out  64     latched nonce
//   core_data_in         out  512    registered plaintext; stable from request until core_data_out_valid
//   core_ready           in   1      core idle
//   core_data_out_valid  in   1      1-cycle result strobe
//   core_data_out        in   512    core result
//
// BEHAVIOUR
//   Reset: all outputs and registers 0; FSM in IDLE. Reset is legal in any state and abandons the message
//     (the core is reset by the same source).
//   FSM states and transitions:
//     - IDLE:  start=1 latches cfg_*, clears err, busy<=1. num_blocks==0 -> DONE, else -> FETCH.
//     - FETCH: s_ready=1. On s_valid&&s_ready, register s_data into core_data_in -> ISSUE.
//     - ISSUE: wait for core_ready=1, then pulse exactly one cycle of core_init (first block) or core_next (others) -> BUSY.
//     - BUSY:  on core_data_out_valid, capture core_data_out into m_data, ctr<=ctr+1 (mod 2^64), remaining-=1 -> EMIT.
//     - EMIT:  m_valid=1, m_last=(remaining==0). m_data/m_last held stable until m_ready.
//         On handshake: remaining!=0 -> FETCH, else -> DONE.
//     - DONE:  done=1 for one cycle, busy<=0 -> IDLE.
//   Signal rules:
//     - s_ready is asserted only in FETCH; m_valid only in EMIT; core_init and core_next are never both asserted.
//     - No overlap: the next input block is not accepted until the prior output beat has handshaken.
//     - Minimum per-block latency is s-handshake -> request 1 cycle, plus core latency, plus 1 cycle to m_valid.
//   Boundary cases:
//     - start while busy: ignored, no state change.
//     - m_ready held low: indefinite stall in EMIT; the core is not re-requested.
//     - core_data_out_valid outside BUSY: ignored.
//     - 64-bit counter overflow wraps to 0 unless the macro is defined.
//
// CONFIGURATION
//   CHACHA_CTRL_CTR_WRAP_ERR_EN:
//     - Defined: when the captured block used ctr==2^64-1 and remaining!=0, the current block is still emitted,
//       then the FSM sets err=1 and goes EMIT -> DONE without issuing further requests.
//     - Undefined: err tied 0; the counter wraps silently.
//
// TESTING
//   - num=3, ctr0=5:
//       -> core_init with ctr=5, then core_next with ctr=6 and ctr=7.
//       -> 3 m beats, m_data = core_data_out each time; m_last only on the 3rd; done 1 cycle after the 3rd handshake.
//   - m_ready low 10 cycles during EMIT
//       -> m_data/m_valid stable; s_ready=0; no core request; resumes on m_ready.
//   - num=0 -> done pulses 2 cycles after start; no core_init/next; s_ready never 1.
//   - start pulsed again in BUSY with a different key -> core_key unchanged; block count unaffected.
//   - reset asserted in BUSY -> next edge: busy, m_valid, s_ready, core_init/next all 0; FSM IDLE.
//   - macro on, ctr0=FFFF_FFFF_FFFF_FFFF, num=2
//       -> one m beat, then err=1 and done; no second request.
//     Macro off, same stimulus -> 2nd request has ctr=0 and err stays 0.

Source files
------------

// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: feeds a multi-block message through a single-block ChaCha core, one request per block.
// Define CHACHA_CTRL_CTR_WRAP_ERR_EN to stop the message with a sticky err on block-counter wrap.
module chacha_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [255:0]       cfg_key,
    input  logic [63:0]        cfg_iv,
    input  logic [63:0]        cfg_ctr0,
    input  logic [CNT_W-1:0]   cfg_num_blocks,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [511:0]       s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [511:0]       m_data,
    output logic               m_last,
    output logic               core_init,
    output logic               core_next,
    output logic [255:0]       core_key,
    output logic [63:0]        core_ctr,
    output logic [63:0]        core_iv,
    output logic [511:0]       core_data_in,
    input  logic               core_ready,
    input  logic               core_data_out_valid,
    input  logic [511:0]       core_data_out
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_EMIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic [255:0]     key_reg;
    logic [63:0]      iv_reg;
    logic [63:0]      ctr_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             first_reg;
    logic [511:0]     data_in_reg;
    logic [511:0]     m_data_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             core_init_reg;
    logic             core_next_reg;
    logic             wrap_stop;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (cfg_num_blocks == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (s_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (core_data_out_valid) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    state_next = ((remaining_reg == '0) || wrap_stop) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            key_reg       <= '0;
            iv_reg        <= '0;
            ctr_reg       <= '0;
            remaining_reg <= '0;
            first_reg     <= 1'b0;
            data_in_reg   <= '0;
            m_data_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            core_init_reg <= 1'b0;
            core_next_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_reg      <= 1'b0;
            core_init_reg <= 1'b0;
            core_next_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        key_reg       <= cfg_key;
                        iv_reg        <= cfg_iv;
                        ctr_reg       <= cfg_ctr0;
                        remaining_reg <= cfg_num_blocks;
                        first_reg     <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        data_in_reg <= s_data;
                    end
                end
                ST_ISSUE: begin
                    // Request pulses are registered so they last exactly one cycle.
                    if (core_ready) begin
                        core_init_reg <= first_reg;
                        core_next_reg <= ~first_reg;
                        first_reg     <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (core_data_out_valid) begin
                        m_data_reg    <= core_data_out;
                        ctr_reg       <= ctr_reg + 64'd1;
                        remaining_reg <= remaining_reg - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHACHA_CTRL_CTR_WRAP_ERR_EN
    logic err_reg;
    logic wrap_reg;

    // wrap_reg marks that the block just captured consumed the last counter value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg  <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                err_reg  <= 1'b0;
                wrap_reg <= 1'b0;
            end
            if (state_reg == ST_BUSY && core_data_out_valid) begin
                wrap_reg <= (ctr_reg == '1);
            end
            if (state_reg == ST_EMIT && m_ready && remaining_reg != '0 && wrap_reg) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err       = err_reg;
    assign wrap_stop = wrap_reg;
`else
    assign err       = 1'b0;
    assign wrap_stop = 1'b0;
`endif

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign s_ready      = (state_reg == ST_FETCH);
    assign m_valid      = (state_reg == ST_EMIT);
    assign m_last       = (state_reg == ST_EMIT) && (remaining_reg == '0);
    assign m_data       = m_data_reg;
    assign core_init    = core_init_reg;
    assign core_next    = core_next_reg;
    assign core_key     = key_reg;
    assign core_iv      = iv_reg;
    assign core_ctr     = ctr_reg;
    assign core_data_in = data_in_reg;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl: behavioural core model, request and output scoreboards.
module tb_chacha_stream_ctrl;
    localparam int CNT_W = 16;

    logic               clk;
    logic               reset;
    logic               start;
    logic [255:0]       cfg_key;
    logic [63:0]        cfg_iv;
    logic [63:0]        cfg_ctr0;
    logic [CNT_W-1:0]   cfg_num_blocks;
    logic               busy;
    logic               done;
    logic               err;
    logic               s_valid;
    logic               s_ready;
    logic [511:0]       s_data;
    logic               m_valid;
    logic               m_ready;
    logic [511:0]       m_data;
    logic               m_last;
    logic               core_init;
    logic               core_next;
    logic [255:0]       core_key;
    logic [63:0]        core_ctr;
    logic [63:0]        core_iv;
    logic [511:0]       core_data_in;
    logic               core_ready;
    logic               core_data_out_valid;
    logic [511:0]       core_data_out;

    int checks = 0;
    int errors = 0;
    int core_lat = 3;

    logic [64:0]  req_q [$];
    logic [512:0] sb_q [$];
    logic [255:0] exp_key;
    logic [63:0]  exp_iv;

    chacha_stream_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_ctr0(cfg_ctr0), .cfg_num_blocks(cfg_num_blocks),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_init(core_init), .core_next(core_next), .core_key(core_key), .core_ctr(core_ctr),
        .core_iv(core_iv), .core_data_in(core_data_in), .core_ready(core_ready),
        .core_data_out_valid(core_data_out_valid), .core_data_out(core_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] ks(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
        logic [511:0] r;
        r = {k, k[127:0] ^ {n, c}, {2{c ^ 64'h0123_4567_89ab_cdef}}};
        return r ^ {8{n + c}};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: result = data ^ keystream(key, iv, ctr seen at request), data taken at result time.
    initial begin
        logic [255:0] k;
        logic [63:0]  n, c;
        logic [64:0]  e;
        core_ready = 1'b1;
        core_data_out_valid = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            if (core_init || core_next) begin
                k = core_key;
                n = core_iv;
                c = core_ctr;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_req observed=%0h expected=none", {core_init, core_next, core_ctr});
                end else begin
                    e = req_q.pop_front();
                    chk("req_type", {510'd0, core_init, core_next}, {510'd0, e[64], ~e[64]});
                    chk("req_ctr", core_ctr, e[63:0]);
                end
                core_ready = 1'b0;
                repeat (core_lat) @(negedge clk);
                core_data_out = core_data_in ^ ks(k, n, c);
                core_data_out_valid = 1'b1;
                @(negedge clk);
                core_data_out_valid = 1'b0;
                core_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c,
                            input logic [CNT_W-1:0] num);
        cfg_key = k;
        cfg_iv = n;
        cfg_ctr0 = c;
        cfg_num_blocks = num;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] pt, input logic first, input logic [63:0] ctr,
                              input logic last);
        int n;
        req_q.push_back({first, ctr});
        sb_q.push_back({last, pt ^ ks(exp_key, exp_iv, ctr)});
        s_data = pt;
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready", {511'd0, s_ready}, 512'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic recv_block(input int stall);
        logic [512:0] e;
        int n;
        e = sb_q.pop_front();
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid", {511'd0, m_valid}, 512'd1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_m_data", m_data, e[511:0]);
            chk("stall_m_valid", {511'd0, m_valid}, 512'd1);
            chk("stall_s_ready", {511'd0, s_ready}, 512'd0);
            @(negedge clk);
        end
        chk("m_data", m_data, e[511:0]);
        chk("m_last", {511'd0, m_last}, {511'd0, e[512]});
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("done_early", {511'd0, done}, 512'd0);
        chk("done_s_ready", {511'd0, s_ready}, 512'd0);
        @(negedge clk);
        chk("done", {511'd0, done}, 512'd1);
        chk("done_busy", {511'd0, busy}, 512'd0);
        chk("done_s_ready2", {511'd0, s_ready}, 512'd0);
        @(negedge clk);
        chk("done_pulse", {511'd0, done}, 512'd0);
        tick();
    endtask

    initial begin
        logic [255:0] k1, k2, k3;
        logic [63:0]  n1, n2;
        k1 = {8{32'hA5A5_1234}};
        k2 = {4{64'h0F1E_2D3C_4B5A_6978}};
        k3 = {8{32'hDEAD_BEEF}};
        n1 = 64'h1111_2222_3333_4444;
        n2 = 64'hCAFE_F00D_0BAD_BEEF;
        reset = 1'b1;
        start = 1'b0;
        cfg_key = '0;
        cfg_iv = '0;
        cfg_ctr0 = '0;
        cfg_num_blocks = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {511'd0, busy}, 512'd0);
        chk("rst_done", {511'd0, done}, 512'd0);
        chk("rst_err", {511'd0, err}, 512'd0);
        chk("rst_s_ready", {511'd0, s_ready}, 512'd0);
        chk("rst_m_valid", {511'd0, m_valid}, 512'd0);
        chk("rst_req", {510'd0, core_init, core_next}, 512'd0);
        chk("rst_ctr", {448'd0, core_ctr}, 512'd0);
        chk("rst_m_data", m_data, 512'd0);
        reset = 1'b0;
        tick();

        // num=3, ctr0=5
        exp_key = k1;
        exp_iv = n1;
        do_start(k1, n1, 64'd5, 3);
        chk("busy_after_start", {511'd0, busy}, 512'd1);
        for (int i = 0; i < 3; i++) begin
            send_block(rnd512(), i == 0, 64'd5 + 64'(i), i == 2);
            recv_block(0);
        end
        check_done();
        chk("err_clear", {511'd0, err}, 512'd0);

        // output stall of 10 cycles on first beat
        exp_key = k2;
        exp_iv = n2;
        do_start(k2, n2, 64'd40, 2);
        send_block(rnd512(), 1'b1, 64'd40, 1'b0);
        recv_block(10);
        send_block(rnd512(), 1'b0, 64'd41, 1'b1);
        recv_block(0);
        check_done();

        // empty message
        do_start(k1, n1, 64'd9, 0);
        check_done();

        // start while busy is ignored
        core_lat = 6;
        exp_key = k2;
        exp_iv = n2;
        do_start(k2, n2, 64'd100, 2);
        send_block(rnd512(), 1'b1, 64'd100, 1'b0);
        tick();
        do_start(k3, n1, 64'd999, 7);
        chk("key_kept", {256'd0, core_key}, {256'd0, k2});
        chk("iv_kept", {448'd0, core_iv}, {448'd0, n2});
        recv_block(0);
        send_block(rnd512(), 1'b0, 64'd101, 1'b1);
        recv_block(0);
        check_done();

        // reset in BUSY; the late core result must be ignored
        core_lat = 20;
        exp_key = k1;
        exp_iv = n1;
        do_start(k1, n1, 64'd7, 2);
        send_block(rnd512(), 1'b1, 64'd7, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rstb_busy", {511'd0, busy}, 512'd0);
        chk("rstb_m_valid", {511'd0, m_valid}, 512'd0);
        chk("rstb_s_ready", {511'd0, s_ready}, 512'd0);
        chk("rstb_req", {510'd0, core_init, core_next}, 512'd0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst_m_valid", {511'd0, m_valid}, 512'd0);
            chk("post_rst_busy", {511'd0, busy}, 512'd0);
        end
        tick();
        core_lat = 3;

        // counter at 2^64-1 with two blocks
        exp_key = k2;
        exp_iv = n1;
        do_start(k2, n1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        send_block(rnd512(), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        recv_block(0);
`ifdef CHACHA_CTRL_CTR_WRAP_ERR_EN
        chk("wrap_err", {511'd0, err}, 512'd1);
        check_done();
        chk("wrap_err_sticky", {511'd0, err}, 512'd1);
`else
        chk("wrap_no_err", {511'd0, err}, 512'd0);
        send_block(rnd512(), 1'b0, 64'd0, 1'b1);
        recv_block(0);
        check_done();
        chk("wrap_no_err_end", {511'd0, err}, 512'd0);
`endif

        repeat (5) tick();
        chk("req_q_empty", 512'(req_q.size()), 512'd0);
        chk("sb_q_empty", 512'(sb_q.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
